// File: rtl/mod_pack_if.sv
// Destination FIFO write port of the packing stage: packed word, write strobe,
// last-word tag and the two FIFO fill-level flags.
interface mod_pack_if #(
   parameter int OUT_W = 64
);
   logic [OUT_W-1:0] m_dst;
   logic             m_dst_putn;
   logic             m_dst_last;
   logic             m_dst_full;
   logic             m_dst_almost_full;

   modport master (
      output m_dst,
      output m_dst_putn,
      output m_dst_last,
      input  m_dst_full,
      input  m_dst_almost_full
   );

   modport slave (
      input  m_dst,
      input  m_dst_putn,
      input  m_dst_last,
      output m_dst_full,
      output m_dst_almost_full
   );
endinterface

// File: rtl/mod_pack.sv
// Output packer: selects one of N_CH engine streams by descriptor bits, packs
// IN_W words LSB-lane-first into OUT_W words, flushes, tags last and pulses end.
module mod_pack #(
   parameter int N_CH    = 2,
   parameter int IN_W    = 16,
   parameter int OUT_W   = 64,
   parameter int SEL_LSB = 5
) (
   input  logic                 wb_clk_i,
   input  logic                 m_resetn,
   input  logic                 m_enable,
   input  logic [23:0]          dc,
   input  logic [N_CH*IN_W-1:0] in_data,
   input  logic [N_CH-1:0]      in_valid,
   input  logic [N_CH-1:0]      in_done,
   output logic [N_CH-1:0]      in_ready,
   mod_pack_if.master           dst,
   output logic                 m_endn,
   output logic [31:0]          m_words,
   output logic                 m_err
);

   localparam int RATIO  = OUT_W / IN_W;
   localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam int SEL_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(RATIO - 1);
   localparam logic [23:0] SEL_MASK = 24'((32'd1 << N_CH) - 32'd1) << SEL_LSB;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PACK  = 2'd1,
      S_FLUSH = 2'd2,
      S_END   = 2'd3
   } state_t;

   function automatic logic multi_hot(input logic [N_CH-1:0] v);
      return (v & (v - N_CH'(1))) != '0;
   endfunction

   function automatic logic one_hot(input logic [N_CH-1:0] v);
      return (v != '0) && !multi_hot(v);
   endfunction

   function automatic logic [SEL_W-1:0] hot_index(input logic [N_CH-1:0] v);
      logic [SEL_W-1:0] idx;
      idx = '0;
      for (int k = 0; k < N_CH; k++) begin
         idx = v[k] ? SEL_W'(k) : idx;
      end
      return idx;
   endfunction

   state_t           state_r;
   logic [SEL_W-1:0] sel_idx_r;
   logic [OUT_W-1:0] pack_r;
   logic [LANE_W-1:0] lane_cnt_r;
   logic [OUT_W-1:0] hold_r;
   logic             hold_v_r;
   logic [OUT_W-1:0] dst_r;
   logic             putn_r;
   logic             last_r;
   logic             endn_r;
   logic             pend_r;
   logic [31:0]      words_r;
   logic             err_r;

   logic [N_CH-1:0]  sel_field_s;
   logic             fo_full_s;
   logic [IN_W-1:0]  word_s;
   logic             valid_sel_s;
   logic             done_sel_s;
   logic             ready_s;
   logic             accept_s;
   logic             done_take_s;
   logic [OUT_W-1:0] pack_nxt_s;
   logic             dc_unused_s;

   assign sel_field_s = dc[SEL_LSB +: N_CH];
   assign fo_full_s   = dst.m_dst_full | dst.m_dst_almost_full;
   assign dc_unused_s = ^(dc & ~SEL_MASK);

   // Selected-channel handshake and the pack word with the incoming lane merged in
   always_comb begin
      word_s      = in_data[int'(sel_idx_r)*IN_W +: IN_W];
      valid_sel_s = in_valid[sel_idx_r];
      done_sel_s  = in_done[sel_idx_r];
      // A full hold with nowhere to go blocks the lane-0 accept that would push it out
      ready_s     = !(hold_v_r && (lane_cnt_r == '0) && fo_full_s);
      in_ready    = '0;
      if (state_r == S_PACK) begin
         in_ready[sel_idx_r] = ready_s;
      end else begin
         in_ready = '0;
      end
      accept_s    = (state_r == S_PACK) && valid_sel_s && ready_s;
      done_take_s = (state_r == S_PACK) && done_sel_s && (!valid_sel_s || ready_s);
      pack_nxt_s  = pack_r;
      pack_nxt_s[int'(lane_cnt_r)*IN_W +: IN_W] = word_s;
   end

   // Job sequencer: channel latch, lane packing, hold/flush emission, end pulse
   always_ff @(posedge wb_clk_i) begin
      if (!m_resetn) begin
         state_r    <= S_IDLE;
         sel_idx_r  <= '0;
         pack_r     <= '0;
         lane_cnt_r <= '0;
         hold_r     <= '0;
         hold_v_r   <= 1'b0;
         dst_r      <= '0;
         putn_r     <= 1'b1;
         last_r     <= 1'b0;
         endn_r     <= 1'b1;
         pend_r     <= 1'b0;
         words_r    <= 32'd0;
         err_r      <= 1'b0;
      end else begin
         putn_r <= 1'b1;
         last_r <= 1'b0;
         endn_r <= 1'b1;
         err_r  <= m_enable && multi_hot(sel_field_s);
         case (state_r)
            S_IDLE: begin
               if (m_enable && one_hot(sel_field_s)) begin
                  sel_idx_r  <= hot_index(sel_field_s);
                  words_r    <= 32'd0;
                  lane_cnt_r <= '0;
                  pack_r     <= '0;
                  hold_v_r   <= 1'b0;
                  state_r    <= S_PACK;
               end else begin
                  state_r <= S_IDLE;
               end
            end
            S_PACK: begin
               if (!m_enable) begin
                  hold_v_r   <= 1'b0;
                  lane_cnt_r <= '0;
                  pack_r     <= '0;
                  state_r    <= S_IDLE;
               end else begin
                  if (accept_s) begin
                     words_r <= (words_r == 32'hFFFF_FFFF) ? words_r : words_r + 32'd1;
                     if (lane_cnt_r == LANE_LAST) begin
                        hold_r     <= pack_nxt_s;
                        hold_v_r   <= 1'b1;
                        pack_r     <= '0;
                        lane_cnt_r <= '0;
                     end else begin
                        pack_r     <= pack_nxt_s;
                        lane_cnt_r <= lane_cnt_r + LANE_W'(1);
                     end
                     if ((lane_cnt_r == '0) && hold_v_r) begin
                        dst_r    <= hold_r;
                        putn_r   <= 1'b0;
                        hold_v_r <= 1'b0;
                     end else begin
                        putn_r <= 1'b1;
                     end
                  end else begin
                     putn_r <= 1'b1;
                  end
                  state_r <= done_take_s ? S_FLUSH : S_PACK;
               end
            end
            S_FLUSH: begin
               if (!m_enable) begin
                  hold_v_r   <= 1'b0;
                  lane_cnt_r <= '0;
                  pack_r     <= '0;
                  state_r    <= S_IDLE;
               end else if (fo_full_s) begin
                  state_r <= S_FLUSH;
               end else if (hold_v_r) begin
                  dst_r    <= hold_r;
                  putn_r   <= 1'b0;
                  hold_v_r <= 1'b0;
                  if (lane_cnt_r == '0) begin
                     last_r  <= 1'b1;
                     pend_r  <= 1'b1;
                     state_r <= S_END;
                  end else begin
                     state_r <= S_FLUSH;
                  end
               end else begin
                  // Partial or empty job: unused lanes of pack_r are already zero
                  dst_r      <= pack_r;
                  putn_r     <= 1'b0;
                  last_r     <= 1'b1;
                  pack_r     <= '0;
                  lane_cnt_r <= '0;
                  pend_r     <= 1'b1;
                  state_r    <= S_END;
               end
            end
            S_END: begin
               endn_r <= !pend_r;
               pend_r <= 1'b0;
               if (!m_enable || (sel_field_s == '0)) begin
                  state_r <= S_IDLE;
               end else begin
                  state_r <= S_END;
               end
            end
            default: begin
               state_r <= S_IDLE;
            end
         endcase
      end
   end

   assign dst.m_dst      = dst_r;
   assign dst.m_dst_putn = putn_r;
   assign dst.m_dst_last = last_r;
   assign m_endn         = endn_r;
   assign m_words        = words_r;
   assign m_err          = err_r;

endmodule
